// File: rtl/clk_mon_pkg.sv
// ---------------------------------------------------------------------------
// clk_mon_pkg
// Shared types for the divided-clock self-check.
//   mon_state_t : monitor state machine encoding (2 bits)
//     ST_IDLE    - monitoring disabled
//     ST_ARM     - waiting for the first mon_clk edge to start a period
//     ST_ACQUIRE - measuring periods and counting consecutive good ones
//     ST_LOCKED  - clock within tolerance; deviations now raise fault
// ---------------------------------------------------------------------------
package clk_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_ACQUIRE = 2'd2,
        ST_LOCKED  = 2'd3
    } mon_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
// Two-flop synchronizer for an asynchronous level, followed by an edge flop
// and a registered rising-edge pulse.
// Ports:
//   clk        in  system clock
//   resetn     in  asynchronous active-low reset
//   async_in   in  asynchronous level input
//   rise_pulse out one-cycle pulse per detected rising edge, two cycles after
//                  async_in is first sampled high
// ---------------------------------------------------------------------------
module sync_edge_det (
    input  logic clk,
    input  logic resetn,
    input  logic async_in,
    output logic rise_pulse
);

    logic s1_reg;
    logic s2_reg;
    logic s3_reg;
    logic rise_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_reg   <= 1'b0;
            s2_reg   <= 1'b0;
            s3_reg   <= 1'b0;
            rise_reg <= 1'b0;
        end else begin
            s1_reg   <= async_in;
            s2_reg   <= s1_reg;
            s3_reg   <= s2_reg;
            rise_reg <= s2_reg & ~s3_reg;
        end
    end

    assign rise_pulse = rise_reg;

endmodule

// File: rtl/clk_ratio_monitor.sv
// ---------------------------------------------------------------------------
// clk_ratio_monitor
// Measures the period of a divided clock (mon_clk) in clk cycles, locks once
// LOCK_COUNT consecutive periods are within DIV_RATIO +/- TOL, and raises a
// sticky fault if a locked clock deviates or stops.
// Parameters:
//   DIV_RATIO  expected period in clk cycles (>= 2)
//   TOL        allowed absolute deviation in cycles
//   LOCK_COUNT consecutive good periods needed to lock (>= 1)
//   CNT_W      period counter width; DIV_RATIO+TOL < 2^CNT_W-1
// Ports:
//   clk, resetn   system clock, asynchronous active-low reset
//   mon_clk       monitored clock (asynchronous)
//   enable        monitoring enable
//   clear_fault   level clear for fault (a simultaneous set wins)
//   rise_pulse    one-cycle pulse per detected mon_clk rising edge
//   period        last measured period
//   period_valid  one-cycle pulse when period updates
//   locked        state == LOCKED
//   fault         sticky deviation/timeout-while-locked flag
// ---------------------------------------------------------------------------
module clk_ratio_monitor
    import clk_mon_pkg::*;
#(
    parameter int DIV_RATIO  = 4,
    parameter int TOL        = 0,
    parameter int LOCK_COUNT = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             mon_clk,
    input  logic             enable,
    input  logic             clear_fault,
    output logic             rise_pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             fault
);

    localparam int                GOOD_W      = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
    localparam logic [CNT_W:0]    RATIO_X     = (CNT_W+1)'(DIV_RATIO);
    localparam logic [CNT_W:0]    TOL_X       = (CNT_W+1)'(TOL);
    localparam logic [GOOD_W-1:0] LOCK_TARGET = GOOD_W'(LOCK_COUNT);

    mon_state_t        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg;
    logic [CNT_W-1:0]  period_reg;
    logic              period_valid_reg;
    logic [GOOD_W-1:0] good_cnt_reg, good_cnt_next;
    logic              fault_reg;

    logic [CNT_W-1:0]  meas_period;
    logic [CNT_W:0]    meas_x;
    logic [CNT_W:0]    abs_diff;
    logic              period_good;
    logic              measuring;
    logic              timeout;
    logic              fault_set;
    logic [GOOD_W-1:0] good_inc;

    sync_edge_det u_sync (
        .clk        (clk),
        .resetn     (resetn),
        .async_in   (mon_clk),
        .rise_pulse (rise_pulse)
    );

    // Count is the number of full cycles since the last edge, so the period
    // is cnt+1; saturate so a stopped clock cannot wrap into a "good" value.
    assign meas_period = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + 1'b1;

    // Widened by one bit so the absolute difference never wraps.
    assign meas_x      = {1'b0, meas_period};
    assign abs_diff    = (meas_x >= RATIO_X) ? (meas_x - RATIO_X) : (RATIO_X - meas_x);
    assign period_good = (abs_diff <= TOL_X);

    assign measuring = enable && rise_pulse &&
                       ((state_reg == ST_ACQUIRE) || (state_reg == ST_LOCKED));

    // An edge arriving in the saturation cycle counts as a (bad) measurement,
    // not a timeout, so the two never fire together.
    assign timeout   = enable && !rise_pulse && (cnt_reg == CNT_MAX) &&
                       ((state_reg == ST_ACQUIRE) || (state_reg == ST_LOCKED));

    assign good_inc  = good_cnt_reg + 1'b1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_reg <= '0;
        end else if (!enable || rise_pulse) begin
            cnt_reg <= '0;
        end else if (cnt_reg != CNT_MAX) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            period_reg       <= '0;
            period_valid_reg <= 1'b0;
        end else begin
            period_valid_reg <= measuring;
            if (measuring) begin
                period_reg <= meas_period;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= ST_IDLE;
            good_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            good_cnt_reg <= good_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        good_cnt_next = good_cnt_reg;
        fault_set     = 1'b0;
        if (!enable) begin
            state_next    = ST_IDLE;
            good_cnt_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_ARM;
                end
                ST_ARM: begin
                    // First edge only starts the counter; nothing to measure yet.
                    if (rise_pulse) begin
                        state_next    = ST_ACQUIRE;
                        good_cnt_next = '0;
                    end
                end
                ST_ACQUIRE: begin
                    if (measuring) begin
                        if (period_good) begin
                            good_cnt_next = good_inc;
                            if (good_inc == LOCK_TARGET) begin
                                state_next = ST_LOCKED;
                            end
                        end else begin
                            good_cnt_next = '0;
                        end
                    end else if (timeout) begin
                        state_next = ST_ARM;
                    end
                end
                ST_LOCKED: begin
                    if (measuring && !period_good) begin
                        fault_set     = 1'b1;
                        state_next    = ST_ACQUIRE;
                        good_cnt_next = '0;
                    end else if (timeout) begin
                        fault_set  = 1'b1;
                        state_next = ST_ARM;
                    end
                end
                default: begin
                    state_next    = ST_IDLE;
                    good_cnt_next = '0;
                end
            endcase
        end
    end

    // Held while disabled; a new fault takes priority over a clear request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fault_reg <= 1'b0;
        end else if (fault_set) begin
            fault_reg <= 1'b1;
        end else if (enable && clear_fault) begin
            fault_reg <= 1'b0;
        end
    end

    assign period       = period_reg;
    assign period_valid = period_valid_reg;
    assign locked       = (state_reg == ST_LOCKED);
    assign fault        = fault_reg;

endmodule

// File: tb/tb_clk_ratio_monitor.sv
module tb_clk_ratio_monitor;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic             mon_clk = 1'b0;
    logic             enable = 1'b0;
    logic             clear_fault = 1'b0;
    logic             rise_pulse;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             fault;

    always #5 clk = ~clk;

    clk_ratio_monitor #(
        .DIV_RATIO  (4),
        .TOL        (0),
        .LOCK_COUNT (4),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .mon_clk      (mon_clk),
        .enable       (enable),
        .clear_fault  (clear_fault),
        .rise_pulse   (rise_pulse),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .fault        (fault)
    );

    // One record per mon_clk period: high/low phase lengths, and the result
    // expected from the period_valid caused by the rising edge that starts it.
    typedef struct {
        int hi;
        int lo;
        bit pv;
        int per;
        bit lk;
        bit ft;
    } vec_t;

    typedef struct {
        int per;
        bit lk;
        bit ft;
    } obs_t;

    vec_t vecs[$];
    obs_t obs_q[$];
    int   tests = 0;
    int   fails = 0;

    always @(negedge clk) begin
        if (period_valid === 1'b1) begin
            obs_q.push_back('{int'(period), locked, fault});
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input int hi, input int lo, input bit pv, input int per,
                       input bit lk, input bit ft);
        vecs.push_back('{hi, lo, pv, per, lk, ft});
    endtask

    task automatic run_seg(input int first, input int last, input string tag);
        obs_t o;
        obs_q.delete();
        for (int i = first; i <= last; i++) begin
            mon_clk = 1'b1;
            repeat (vecs[i].hi) @(negedge clk);
            mon_clk = 1'b0;
            repeat (vecs[i].lo) @(negedge clk);
        end
        repeat (6) @(negedge clk);
        for (int i = first; i <= last; i++) begin
            if (vecs[i].pv) begin
                if (obs_q.size() == 0) begin
                    check($sformatf("%s_vec%0d_present", tag, i), 0, 1);
                end else begin
                    o = obs_q.pop_front();
                    $display("[TB] %s vec %0d: period=%0d locked=%0d fault=%0d (exp %0d/%0d/%0d)",
                             tag, i, o.per, o.lk, o.ft, vecs[i].per, vecs[i].lk, vecs[i].ft);
                    check($sformatf("%s_vec%0d_period", tag, i), o.per, vecs[i].per);
                    check($sformatf("%s_vec%0d_locked", tag, i), o.lk, vecs[i].lk);
                    check($sformatf("%s_vec%0d_fault", tag, i), o.ft, vecs[i].ft);
                end
            end else begin
                $display("[TB] %s vec %0d: arming edge, no measurement expected", tag, i);
            end
        end
        check($sformatf("%s_extra_period_valid", tag), obs_q.size(), 0);
        obs_q.delete();
    endtask

    initial begin
        int a0, a1, b0, b1, c0, c1;
        int k;

        // Segment A: /4 lock, stretched high phase, relock with sticky fault.
        a0 = vecs.size();
        add(2, 2, 0, 0, 0, 0);
        add(2, 2, 1, 4, 0, 0);
        add(2, 2, 1, 4, 0, 0);
        add(2, 2, 1, 4, 0, 0);
        add(2, 2, 1, 4, 1, 0);
        add(2, 2, 1, 4, 1, 0);
        add(4, 2, 1, 4, 1, 0);
        add(2, 2, 1, 6, 0, 1);
        add(2, 2, 1, 4, 0, 1);
        add(2, 2, 1, 4, 0, 1);
        add(2, 2, 1, 4, 0, 1);
        add(2, 2, 1, 4, 1, 1);
        add(2, 2, 1, 4, 1, 1);
        a1 = vecs.size() - 1;
        // Segment B: from ARM, /2 never locks, then /4 locks.
        b0 = vecs.size();
        add(1, 1, 0, 0, 0, 0);
        add(1, 1, 1, 2, 0, 0);
        add(1, 1, 1, 2, 0, 0);
        add(1, 1, 1, 2, 0, 0);
        add(1, 1, 1, 2, 0, 0);
        add(2, 2, 1, 2, 0, 0);
        add(2, 2, 1, 4, 0, 0);
        add(2, 2, 1, 4, 0, 0);
        add(2, 2, 1, 4, 0, 0);
        add(2, 2, 1, 4, 1, 0);
        b1 = vecs.size() - 1;
        // Segment C: after reset, full ARM/ACQUIRE again, lock at 5th rise.
        c0 = vecs.size();
        add(2, 2, 0, 0, 0, 0);
        add(2, 2, 1, 4, 0, 0);
        add(2, 2, 1, 4, 0, 0);
        add(2, 2, 1, 4, 0, 0);
        add(2, 2, 1, 4, 1, 0);
        c1 = vecs.size() - 1;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outputs", {rise_pulse, period_valid, locked, fault}, 0);
        check("reset_period", period, 0);
        $display("[TB] reset: period=%0d locked=%0d fault=%0d", period, locked, fault);
        resetn = 1'b1;
        enable = 1'b1;
        @(negedge clk);

        run_seg(a0, a1, "A");

        // Clear the sticky fault while still locked.
        clear_fault = 1'b1;
        @(negedge clk);
        clear_fault = 1'b0;
        check("clear_fault_fault", fault, 0);
        check("clear_fault_locked", locked, 1);
        $display("[TB] clear: locked=%0d fault=%0d", locked, fault);

        // mon_clk held low: no early timeout, then fault and unlock.
        repeat (200) @(negedge clk);
        check("no_early_timeout", locked, 1);
        k = 0;
        while (locked === 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("timeout_unlock", locked, 0);
        check("timeout_fault", fault, 1);
        check("timeout_period_held", period, 4);
        $display("[TB] timeout: locked=%0d fault=%0d period=%0d", locked, fault, period);

        clear_fault = 1'b1;
        @(negedge clk);
        clear_fault = 1'b0;
        check("clear_after_timeout", fault, 0);

        run_seg(b0, b1, "B");

        // Asynchronous reset while locked.
        resetn = 1'b0;
        #1;
        check("midreset_flags", {rise_pulse, period_valid, locked, fault}, 0);
        check("midreset_period", period, 0);
        $display("[TB] mid-reset: period=%0d locked=%0d fault=%0d", period, locked, fault);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        run_seg(c0, c1, "C");

        // Bad period while locked with clear_fault asserted in the same cycle.
        mon_clk = 1'b1;
        k = 0;
        while (rise_pulse !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("edge_latency", k, 3);
        clear_fault = 1'b1;
        @(negedge clk);
        clear_fault = 1'b0;
        check("rise_pulse_width", rise_pulse, 0);
        check("set_wins_fault", fault, 1);
        check("set_wins_unlock", locked, 0);
        $display("[TB] set-vs-clear: locked=%0d fault=%0d period=%0d", locked, fault, period);
        mon_clk = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/clk_ratio_monitor.md
# clk_ratio_monitor

Checks a divided clock against the system clock. The block samples a slower clock `mon_clk` in the `clk` domain, such as a /2 or /4 divider output. On every rising edge of `mon_clk` it measures the period in `clk` cycles and compares it with the expected ratio. It asserts `locked` after enough consecutive good periods, and raises a sticky `fault` when a locked clock drifts or stops. It sits beside the clock dividers as their built-in self-check.

## Interface
- `DIV_RATIO`, 4: expected `mon_clk` period in `clk` cycles; must be ≥ 2.
- `TOL`, 0: allowed absolute deviation from `DIV_RATIO`, in cycles.
- `LOCK_COUNT`, 4: consecutive good periods required to lock; must be ≥ 1.
- `CNT_W`, 8: width of the period counter; `DIV_RATIO+TOL` must be < 2^CNT_W−1.
- `clk`  in  1  system clock.
- `resetn`  in  1  reset, asynchronous, active-low; clock `clk`.
- `mon_clk`  in  1  monitored clock, treated as asynchronous.
- `enable`  in  1  monitoring enable.
- `clear_fault`  in  1  clears `fault` (level).
- `rise_pulse`  out  1  one-cycle pulse for each detected `mon_clk` rising edge.
- `period`  out  CNT_W  last measured period, in `clk` cycles.
- `period_valid`  out  1  one-cycle pulse when `period` is updated.
- `locked`  out  1  monitored clock is within tolerance.
- `fault`  out  1  sticky error: deviation or timeout while locked.

## Operation
- Synchronizer and edge detection:
  - `mon_clk` passes through two flops (s1, s2), then an edge flop (s3).
  - `rise_pulse` is registered as s2 & ~s3.
- Cycle counter `cnt`:
  - Clears to 0 on `rise_pulse`.
  - Otherwise increments each cycle, saturating at 2^CNT_W−1.
  - Saturation means timeout.
- Period measurement:
  - On `rise_pulse` in ACQUIRE or LOCKED, `period` ← `cnt`+1 and `period_valid` pulses.
  - The +1 is saturating, so a synchronous /4 clock yields 4.
  - Measurements are never taken in IDLE or ARM.
- A period is good when |`period` − `DIV_RATIO`| ≤ `TOL`. Compare in CNT_W+1 bits, unsigned, with no wrap.
- State machine, with a `good_cnt` counter:
  - Any state, `enable`=0: go to IDLE, clear `cnt` and `good_cnt`. `fault` and `period` are held.
  - IDLE, `enable`=1: go to ARM.
  - ARM, rise: go to ACQUIRE with `good_cnt`=0. This first edge only arms; no measurement is taken.
  - ACQUIRE, good period: `good_cnt`++. When it reaches `LOCK_COUNT`, go to LOCKED.
  - ACQUIRE, bad period: set `good_cnt`=0 and stay in ACQUIRE.
  - ACQUIRE, timeout: go to ARM.
  - LOCKED, bad period: set `fault`, go to ACQUIRE with `good_cnt`=0.
  - LOCKED, timeout: set `fault`, go to ARM.
- `locked` = (state == LOCKED).
- `fault` behaviour:
  - Set only from LOCKED.
  - Cleared by `clear_fault`.
  - If set and clear occur in the same cycle, set wins.
- Reset mid-operation: all state clears immediately. After release the block needs a full ARM → ACQUIRE sequence again.

## Timing
- Values during reset:
  - `rise_pulse`, `period`, `period_valid`, `locked` and `fault` are all 0.
  - State is IDLE; s1–s3, `cnt` and `good_cnt` are 0.
- Edge latency: if `mon_clk` is first sampled high at `clk` edge N, `rise_pulse` is high from edge N+2 to N+3.
- Measurement update:
  - `period`, `period_valid`, state and `fault` update on the edge after `rise_pulse`, i.e. N+3.
  - `locked` rises or falls in the same cycle as the deciding `period_valid`.
- Minimum monitored period: `mon_clk` high and low phases must each be ≥ 1 `clk` period. Narrower pulses may be missed; this is not detected.
- Timeout is declared in the cycle in which `cnt` reaches 2^CNT_W−1.
- `period` is not updated on timeout.

## Structure
- Package `clk_mon_pkg`: the state enum (IDLE, ARM, ACQUIRE, LOCKED) and its 2-bit encoding.
- Sub-module `sync_edge_det`: two-flop synchronizer plus registered rising-edge pulse. It is reused for any other asynchronous level input.
- Top level: counter, comparator, state machine and fault flag.

## Test plan
- **Synchronous /4 clock, defaults, `enable`=1:**
  - Every `period_valid` shows `period`=4.
  - `locked`=1 with the 4th `period_valid` (5th rise); `fault`=0.
- **/2 clock with `DIV_RATIO`=4, `TOL`=0:** `period`=2 repeatedly; `locked` and `fault` stay 0.
- **Locked, then one `mon_clk` high phase stretched by 2 cycles:**
  - `period`=6, `locked`→0 and `fault`→1 in the same cycle.
  - Relocks after 4 good periods; `fault` stays 1 until `clear_fault`.
- **Locked, then `mon_clk` held low:**
  - After 255 cycles: `fault`=1, `locked`=0, state ARM.
  - `period` keeps its last value.
- **`resetn` pulsed low while locked:**
  - All outputs are 0 immediately.
  - After release, `locked` returns only at the 5th rise.
- **`clear_fault`=1 in the same cycle as a new bad-period fault:** `fault` ends up 1.
